psr_cond_unit: RTL and testbench
================================

Name: psr_cond_unit

Overview:
- Downstream consumer of the ALU status flags C, L, F, Z, N.
- Holds the processor status register (PSR) and applies masked flag writes from execute.
- Evaluates 4-bit branch/jump condition codes against the PSR, forwarding same-cycle flag writes.
- Provides a one-deep PSR shadow for interrupt entry/return and a software PSR read/write path.

Parameters:
- BYPASS, 1, 1 = `take` sees same-cycle masked flag writes; 0 = `take` uses registered PSR only.
- PSR_W, 16, PSR width. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- flag_we  input  1  apply ALU flags this cycle.
- flags_in  input  5  ALU flags in the order {C,L,F,Z,N}.
- flag_mask  input  5  per-flag update enable, same bit order; a bit at 0 keeps the old flag.
- psr_we  input  1  software PSR write (LPR).
- psr_wdata  input  16  software PSR write data.
- irq_save  input  1  interrupt entry.
- irq_restore  input  1  return from interrupt.
- cond  input  4  condition code to evaluate.
- take  output  1  condition result, combinational.
- psr_q  output  16  current registered PSR.
- ie  output  1  interrupt enable, equal to psr_q[9].

Behaviour:
- PSR layout: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N, bit9 IE. All other bits read 0; writes to them are ignored.
- Reset (async, active-high): psr_q = 0x0000, shadow = 0x0000, ie = 0, take = eval(cond, 0).
- Write priority per cycle, highest first: irq_restore > psr_we > flag_we.
  - irq_restore: psr <= shadow.
  - psr_we: psr <= psr_wdata & 0x02E5.
  - flag_we: each flag with its mask bit set <= flags_in bit; masked-off flags and IE unchanged.
  - The losing write is dropped entirely, not merged.
- irq_save (independent of the write priority above):
  - shadow <= value psr would take this edge absent the save, so a completing flag write is preserved.
  - IE bit of psr is then forced to 0.
  - irq_save and irq_restore asserted together: restore executes, save is ignored, shadow unchanged.
- Effective flags for `take`:
  - BYPASS=1 and flag_we=1 and no higher-priority write: {C,L,F,Z,N} = flag_mask ? flags_in : psr flags.
  - Otherwise: psr_q flags.
- Condition table (L = unsigned a<b, N = signed a<b, Z = equal):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: !L & !Z
  - 5 LS: L | Z
  - 6 GT: !N & !Z
  - 7 LE: N | Z
  - 8 FS: F
  - 9 FC: !F
  - A LO: L
  - B HS: !L
  - C LT: N
  - D GE: !N
  - E UC: 1
  - F never: 0
- Latency:
  - take: 0 cycles, combinational from cond and effective flags.
  - psr_q: updates 1 cycle after any write.
- Reset asserted mid-operation clears PSR and shadow immediately, regardless of clk.

Decomposition:
- Shared package `cpu_pkg`:
  - PSR bit-index constants: PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7, PSR_IE=9.
  - PSR_WMASK = 0x02E5.
  - Condition-code constants (COND_EQ..COND_NV), shared with the instruction decoder.
- One sub-module: `cond_eval`, purely combinational (cond, 5 flags -> take). It is reused by the decoder's static branch predictor.

Test Plan:
- Reset, then flag_we=1, mask=0x1F, flags_in={C0,L1,F0,Z0,N1}, cond=A (LO) same cycle -> take=1 (bypass); next cycle psr_q=0x0084.
- From psr_q=0x0084, flag_we with mask=5'b10010 (C,Z only), flags_in=5'b10010 -> psr_q=0x00C5 (L and N retained, C and Z set); cond=E -> take=1, cond=F -> take=0.
- psr_we=1 with psr_wdata=0xFFFF -> psr_q=0x02E5, ie=1; cond=4 (HI) -> take=0 because L=1.
- psr_q=0x0200, irq_save with same-cycle flag_we setting Z -> shadow=0x0240, psr_q=0x0040, ie=0; later irq_restore -> psr_q=0x0240, ie=1.
- Same edge: irq_restore, psr_we, flag_we all asserted -> psr_q equals shadow; the other writes are dropped.
- Assert reset asynchronously between clock edges while psr_q=0x02E5 -> psr_q=0x0000 before the next edge; cond=0 (EQ) -> take=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PSR bit layout, writable-bit mask, condition codes
// and small helpers for moving the {C,L,F,Z,N} flag vector in and out of the PSR.
package cpu_pkg;

    localparam int PSR_C  = 0;
    localparam int PSR_L  = 2;
    localparam int PSR_F  = 5;
    localparam int PSR_Z  = 6;
    localparam int PSR_N  = 7;
    localparam int PSR_IE = 9;

    localparam logic [15:0] PSR_WMASK = 16'h02E5;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_HI = 4'h4,
        COND_LS = 4'h5,
        COND_GT = 4'h6,
        COND_LE = 4'h7,
        COND_FS = 4'h8,
        COND_FC = 4'h9,
        COND_LO = 4'hA,
        COND_HS = 4'hB,
        COND_LT = 4'hC,
        COND_GE = 4'hD,
        COND_UC = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Flag vector order is {C,L,F,Z,N}, matching the ALU output.
    function automatic logic [4:0] psr_flags(input logic [15:0] psr);
        return {psr[PSR_C], psr[PSR_L], psr[PSR_F], psr[PSR_Z], psr[PSR_N]};
    endfunction

    function automatic logic [15:0] merge_flags(input logic [15:0] psr,
                                                input logic [4:0]  flags,
                                                input logic [4:0]  mask);
        logic [15:0] r;
        r        = psr;
        r[PSR_C] = mask[4] ? flags[4] : psr[PSR_C];
        r[PSR_L] = mask[3] ? flags[3] : psr[PSR_L];
        r[PSR_F] = mask[2] ? flags[2] : psr[PSR_F];
        r[PSR_Z] = mask[1] ? flags[1] : psr[PSR_Z];
        r[PSR_N] = mask[0] ? flags[0] : psr[PSR_N];
        return r;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over the {C,L,F,Z,N} flag vector.
// Shared with the decoder's static branch predictor.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);

    logic c_s, l_s, f_s, z_s, n_s;

    assign {c_s, l_s, f_s, z_s, n_s} = flags;

    // Condition table lookup
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z_s;
            COND_NE: take = !z_s;
            COND_CS: take = c_s;
            COND_CC: take = !c_s;
            COND_HI: take = !l_s && !z_s;
            COND_LS: take = l_s || z_s;
            COND_GT: take = !n_s && !z_s;
            COND_LE: take = n_s || z_s;
            COND_FS: take = f_s;
            COND_FC: take = !f_s;
            COND_LO: take = l_s;
            COND_HS: take = !l_s;
            COND_LT: take = n_s;
            COND_GE: take = !n_s;
            COND_UC: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register with prioritised writes, one-deep interrupt shadow,
// and condition evaluation that can see same-cycle flag writes.
module psr_cond_unit
    import cpu_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int PSR_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic [4:0]       flags_in,
    input  logic [4:0]       flag_mask,
    input  logic             psr_we,
    input  logic [PSR_W-1:0] psr_wdata,
    input  logic             irq_save,
    input  logic             irq_restore,
    input  logic [3:0]       cond,
    output logic             take,
    output logic [PSR_W-1:0] psr_q,
    output logic             ie
);

    logic [15:0] psr_r;
    logic [15:0] shadow_r;
    logic [15:0] psr_nosave_s;
    logic [15:0] psr_next_s;
    logic [15:0] shadow_next_s;
    logic        flag_wins_s;
    logic [4:0]  eval_flags_s;

    assign flag_wins_s = flag_we && !psr_we && !irq_restore;

    // Priority restore > software write > flag write; losers are dropped.
    always_comb begin
        psr_nosave_s = psr_r;
        if (irq_restore) begin
            psr_nosave_s = shadow_r;
        end else if (psr_we) begin
            psr_nosave_s = psr_wdata & PSR_WMASK;
        end else if (flag_we) begin
            psr_nosave_s = merge_flags(psr_r, flags_in, flag_mask);
        end else begin
            psr_nosave_s = psr_r;
        end
    end

    // Interrupt entry snapshots the post-write PSR, then clears IE; restore wins over save.
    always_comb begin
        psr_next_s    = psr_nosave_s;
        shadow_next_s = shadow_r;
        if (irq_save && !irq_restore) begin
            shadow_next_s      = psr_nosave_s;
            psr_next_s[PSR_IE] = 1'b0;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // PSR and shadow state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_r    <= 16'h0000;
            shadow_r <= 16'h0000;
        end else begin
            psr_r    <= psr_next_s;
            shadow_r <= shadow_next_s;
        end
    end

    // Flags seen by the evaluator, optionally forwarding a winning flag write
    always_comb begin
        eval_flags_s = psr_flags(psr_r);
        if ((BYPASS != 0) && flag_wins_s) begin
            eval_flags_s = (flags_in & flag_mask) | (psr_flags(psr_r) & ~flag_mask);
        end else begin
            eval_flags_s = psr_flags(psr_r);
        end
    end

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (eval_flags_s),
        .take  (take)
    );

    assign psr_q = psr_r;
    assign ie    = psr_r[PSR_IE];

endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed self-checking bench for psr_cond_unit with hand-computed expectations.
module tb_psr_cond_unit;

    logic        clk;
    logic        reset;
    logic        flag_we;
    logic [4:0]  flags_in;
    logic [4:0]  flag_mask;
    logic        psr_we;
    logic [15:0] psr_wdata;
    logic        irq_save;
    logic        irq_restore;
    logic [3:0]  cond;
    logic        take;
    logic [15:0] psr_q;
    logic        ie;

    int checks;
    int failures;

    psr_cond_unit #(.BYPASS(1), .PSR_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flag_we     (flag_we),
        .flags_in    (flags_in),
        .flag_mask   (flag_mask),
        .psr_we      (psr_we),
        .psr_wdata   (psr_wdata),
        .irq_save    (irq_save),
        .irq_restore (irq_restore),
        .cond        (cond),
        .take        (take),
        .psr_q       (psr_q),
        .ie          (ie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flag_we     = 1'b0;
        flags_in    = 5'b00000;
        flag_mask   = 5'b00000;
        psr_we      = 1'b0;
        psr_wdata   = 16'h0000;
        irq_save    = 1'b0;
        irq_restore = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        cond     = 4'h0;
        idle();
        #2;
        check("reset_psr", psr_q, 16'h0000);
        check("reset_ie", {15'd0, ie}, 16'h0000);
        check("reset_take_eq", {15'd0, take}, 16'h0000);
        cond = 4'h1;
        #1;
        check("reset_take_ne", {15'd0, take}, 16'h0001);
        tick();
        reset = 1'b0;

        // Full-mask flag write, LO sees it through bypass
        flag_we = 1'b1; flag_mask = 5'h1F; flags_in = 5'b01001; cond = 4'hA;
        #1;
        check("bypass_lo", {15'd0, take}, 16'h0001);
        cond = 4'hB;
        #1;
        check("bypass_hs", {15'd0, take}, 16'h0000);
        tick();
        idle();
        check("flag_full_psr", psr_q, 16'h0084);
        cond = 4'hA;
        #1;
        check("reg_lo", {15'd0, take}, 16'h0001);

        // Partial mask: only C and Z updated
        flag_we = 1'b1; flag_mask = 5'b10010; flags_in = 5'b10010; cond = 4'h0;
        #1;
        check("bypass_eq", {15'd0, take}, 16'h0001);
        tick();
        idle();
        check("flag_masked_psr", psr_q, 16'h00C5);
        cond = 4'hE;
        #1;
        check("uc", {15'd0, take}, 16'h0001);
        cond = 4'hF;
        #1;
        check("nv", {15'd0, take}, 16'h0000);

        // Software write masks reserved bits
        psr_we = 1'b1; psr_wdata = 16'hFFFF;
        tick();
        idle();
        check("psr_we_psr", psr_q, 16'h02E5);
        check("psr_we_ie", {15'd0, ie}, 16'h0001);
        cond = 4'h4;
        #1;
        check("hi_with_l", {15'd0, take}, 16'h0000);
        cond = 4'h8;
        #1;
        check("fs", {15'd0, take}, 16'h0001);

        // psr_we beats flag_we; no bypass of the dropped flag write
        psr_we = 1'b1; psr_wdata = 16'h0200;
        flag_we = 1'b1; flag_mask = 5'h1F; flags_in = 5'b00000; cond = 4'h0;
        #1;
        check("no_bypass_under_psr_we", {15'd0, take}, 16'h0001);
        tick();
        idle();
        check("psr_we_over_flag", psr_q, 16'h0200);

        // Interrupt entry with a completing Z write
        irq_save = 1'b1; flag_we = 1'b1; flag_mask = 5'b00010; flags_in = 5'b00010;
        tick();
        idle();
        check("save_psr", psr_q, 16'h0040);
        check("save_ie", {15'd0, ie}, 16'h0000);
        irq_restore = 1'b1;
        tick();
        idle();
        check("restore_psr", psr_q, 16'h0240);
        check("restore_ie", {15'd0, ie}, 16'h0001);

        // All writes plus save on one edge: restore alone takes effect
        psr_we = 1'b1; psr_wdata = 16'h0001;
        tick();
        idle();
        check("pre_collide_psr", psr_q, 16'h0001);
        irq_restore = 1'b1; irq_save = 1'b1;
        psr_we = 1'b1; psr_wdata = 16'hFFFF;
        flag_we = 1'b1; flag_mask = 5'h1F; flags_in = 5'h1F; cond = 4'h6;
        #1;
        check("collide_take_gt", {15'd0, take}, 16'h0001);
        tick();
        idle();
        check("collide_psr", psr_q, 16'h0240);
        psr_we = 1'b1; psr_wdata = 16'h0000;
        tick();
        idle();
        irq_restore = 1'b1;
        tick();
        idle();
        check("shadow_kept", psr_q, 16'h0240);

        // Asynchronous reset between edges
        psr_we = 1'b1; psr_wdata = 16'hFFFF;
        tick();
        idle();
        check("pre_reset_psr", psr_q, 16'h02E5);
        #2;
        reset = 1'b1;
        cond  = 4'h0;
        #1;
        check("async_reset_psr", psr_q, 16'h0000);
        check("async_reset_ie", {15'd0, ie}, 16'h0000);
        check("async_reset_take", {15'd0, take}, 16'h0000);
        tick();
        reset = 1'b0;
        irq_restore = 1'b1;
        tick();
        idle();
        check("reset_shadow", psr_q, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
